// File: rtl/wb_intercon_pkg.sv
// Shared definitions for the Wishbone shared-bus interconnect: FSM encoding,
// watchdog counter width and the supported master/slave counts.
package wb_intercon_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam int WD_W        = 10;
  localparam int MAX_MASTERS = 4;
  localparam int MAX_SLAVES  = 8;

endpackage

// File: rtl/wb_rr_arbiter.sv
// Combinational round-robin pick: the first requester above the one-hot
// last winner, wrapping to index 0. No state, 0-cycle latency.
module wb_rr_arbiter #(
  parameter int n_req = 2
) (
  input  logic [n_req-1:0] req_i,
  input  logic [n_req-1:0] last_i,
  output logic [n_req-1:0] gnt_o
);

  logic found;
  logic after_last;

  always_comb begin
    gnt_o      = '0;
    found      = 1'b0;
    after_last = 1'b0;
    // First pass covers indices strictly above last, second pass wraps from 0.
    for (int i = 0; i < n_req; i++) begin
      if (!found && after_last && req_i[i]) begin
        gnt_o[i] = 1'b1;
        found    = 1'b1;
      end
      if (last_i[i]) after_last = 1'b1;
    end
    for (int i = 0; i < n_req; i++) begin
      if (!found && req_i[i]) begin
        gnt_o[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_intercon.sv
// Wishbone shared-bus interconnect: round-robin master grant held for the whole
// cyc tenure, base/mask slave decode, single-cycle error for unmapped or stalled accesses.
module wb_intercon
  import wb_intercon_pkg::*;
#(
  parameter int                      n_masters  = 2,
  parameter int                      n_slaves   = 6,
  parameter logic [32*n_slaves-1:0]  slave_base = {n_slaves{32'h0}},
  parameter logic [32*n_slaves-1:0]  slave_mask = {n_slaves{32'hF000_0000}},
  parameter int                      timeout    = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [32*n_masters-1:0]   m_adr_i,
  input  logic [32*n_masters-1:0]   m_dat_i,
  input  logic [4*n_masters-1:0]    m_sel_i,
  input  logic [n_masters-1:0]      m_we_i,
  input  logic [n_masters-1:0]      m_cyc_i,
  input  logic [n_masters-1:0]      m_stb_i,
  output logic [31:0]               m_dat_o,
  output logic [n_masters-1:0]      m_ack_o,
  output logic [n_masters-1:0]      m_err_o,
  output logic [n_masters-1:0]      m_rty_o,
  output logic [31:0]               s_adr_o,
  output logic [31:0]               s_dat_o,
  output logic [3:0]                s_sel_o,
  output logic                      s_we_o,
  output logic [n_slaves-1:0]       s_cyc_o,
  output logic [n_slaves-1:0]       s_stb_o,
  input  logic [32*n_slaves-1:0]    s_dat_i,
  input  logic [n_slaves-1:0]       s_ack_i,
  input  logic [n_slaves-1:0]       s_err_i,
  input  logic [n_slaves-1:0]       s_rty_i,
  output logic [n_masters-1:0]      gnt_o
);

  if (n_masters < 1 || n_masters > MAX_MASTERS || n_slaves < 1 || n_slaves > MAX_SLAVES
      || timeout < 0 || timeout > 1023) begin : g_bad_params
    $error("wb_intercon: parameter out of range");
  end

  localparam logic [WD_W-1:0]      TO       = WD_W'(timeout);
  localparam bit                   WD_EN    = (timeout != 0);
  localparam logic [n_masters-1:0] LAST_RST = n_masters'(1) << (n_masters - 1);

  state_e                 state_q;
  logic [n_masters-1:0]   gnt_q;
  logic [n_masters-1:0]   last_q;
  logic [n_masters-1:0]   arb_gnt;
  logic [WD_W-1:0]        wd_cnt_q;
  logic [WD_W-1:0]        wd_cnt_d;
  logic                   err_pend_q;
  logic                   err_pend_d;
  logic                   busy;

  logic [31:0]            g_adr;
  logic [31:0]            g_dat;
  logic [3:0]             g_sel;
  logic                   g_we;
  logic                   g_cyc;
  logic                   g_stb;

  logic [n_slaves-1:0]    sel_oh;
  logic                   dec_found;
  logic                   hit_any;
  logic [31:0]            sel_dat;
  logic                   sel_ack;
  logic                   sel_err;
  logic                   sel_rty;
  logic                   term;
  logic                   unmapped;
  logic                   wd_run;
  logic                   wd_fire;

  assign busy = (state_q == BUSY);

  wb_rr_arbiter #(
    .n_req (n_masters)
  ) u_arb (
    .req_i  (m_cyc_i),
    .last_i (last_q),
    .gnt_o  (arb_gnt)
  );

  always_comb begin
    g_adr = '0;
    g_dat = '0;
    g_sel = '0;
    g_we  = 1'b0;
    g_cyc = 1'b0;
    g_stb = 1'b0;
    for (int m = 0; m < n_masters; m++) begin
      if (gnt_q[m]) begin
        g_adr = m_adr_i[32*m +: 32];
        g_dat = m_dat_i[32*m +: 32];
        g_sel = m_sel_i[4*m +: 4];
        g_we  = m_we_i[m];
        g_cyc = m_cyc_i[m];
        g_stb = m_stb_i[m];
      end
    end
  end

  // Overlapping windows are legal; the lowest-index slave takes the access.
  always_comb begin
    sel_oh    = '0;
    dec_found = 1'b0;
    for (int k = 0; k < n_slaves; k++) begin
      if (busy && !dec_found &&
          ((g_adr & slave_mask[32*k +: 32]) == (slave_base[32*k +: 32] & slave_mask[32*k +: 32]))) begin
        sel_oh[k] = 1'b1;
        dec_found = 1'b1;
      end
    end
  end

  assign hit_any = |sel_oh;

  always_comb begin
    sel_dat = '0;
    sel_ack = 1'b0;
    sel_err = 1'b0;
    sel_rty = 1'b0;
    for (int k = 0; k < n_slaves; k++) begin
      if (sel_oh[k]) begin
        sel_dat = s_dat_i[32*k +: 32];
        sel_ack = s_ack_i[k];
        sel_err = s_err_i[k];
        sel_rty = s_rty_i[k];
      end
    end
  end

  assign term     = sel_ack | sel_err | sel_rty;
  assign unmapped = busy & g_cyc & g_stb & ~hit_any & ~err_pend_q;
  assign wd_run   = WD_EN & busy & g_cyc & g_stb & ~err_pend_q & ~term;
  assign wd_fire  = wd_run & ((wd_cnt_q + 1'b1) == TO);

  // A set err_pending lasts exactly one cycle: both set terms are blocked by it.
  assign err_pend_d = unmapped | wd_fire;
  assign wd_cnt_d   = (wd_run && !err_pend_d) ? wd_cnt_q + 1'b1 : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      last_q     <= LAST_RST;
      wd_cnt_q   <= '0;
      err_pend_q <= 1'b0;
    end else begin
      wd_cnt_q   <= wd_cnt_d;
      err_pend_q <= err_pend_d;
      case (state_q)
        IDLE: begin
          if (|m_cyc_i) begin
            state_q <= BUSY;
            gnt_q   <= arb_gnt;
            last_q  <= arb_gnt;
          end
        end
        BUSY: begin
          if (!g_cyc) begin
            state_q <= IDLE;
            gnt_q   <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_adr_o = g_adr;
  assign s_dat_o = g_dat;
  assign s_sel_o = g_sel;
  assign s_we_o  = g_we;
  assign s_cyc_o = sel_oh & {n_slaves{g_cyc}};
  assign s_stb_o = sel_oh & {n_slaves{g_stb & ~err_pend_q}};

  assign m_dat_o = sel_dat;
  assign m_ack_o = gnt_q & {n_masters{sel_ack}};
  assign m_rty_o = gnt_q & {n_masters{sel_rty}};
  assign m_err_o = gnt_q & {n_masters{sel_err | err_pend_q}};
  assign gnt_o   = gnt_q;

endmodule

// File: tb/tb_wb_intercon.sv
// Bench for wb_intercon: 2 masters, 3 slaves (slave 2 overlaps slave 0), watchdog of 8.
module tb_wb_intercon;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] m_adr = '0;
  logic [63:0] m_dat = '0;
  logic [7:0]  m_sel = '0;
  logic [1:0]  m_we  = '0;
  logic [1:0]  m_cyc = '0;
  logic [1:0]  m_stb = '0;
  logic [31:0] m_dat_o;
  logic [1:0]  m_ack_o, m_err_o, m_rty_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic [3:0]  s_sel_o;
  logic        s_we_o;
  logic [2:0]  s_cyc_o, s_stb_o;
  logic [95:0] s_dat_i;
  logic [2:0]  s_ack_i;
  logic [2:0]  s_err_i = '0;
  logic [2:0]  s_rty_i = '0;
  logic [2:0]  ack_en = '0;
  logic [2:0]  ack_force = '0;
  logic [1:0]  gnt_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          m;
    logic        err;
    logic        chk_dat;
    logic [31:0] dat;
  } exp_t;

  exp_t sb[$];
  exp_t sb_e;

  wb_intercon #(
    .n_masters  (2),
    .n_slaves   (3),
    .slave_base ({32'h0000_0000, 32'h1000_0000, 32'h0000_0000}),
    .slave_mask ({32'hFFFF_0000, 32'hF000_0000, 32'hF000_0000}),
    .timeout    (8)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .m_adr_i (m_adr),
    .m_dat_i (m_dat),
    .m_sel_i (m_sel),
    .m_we_i  (m_we),
    .m_cyc_i (m_cyc),
    .m_stb_i (m_stb),
    .m_dat_o (m_dat_o),
    .m_ack_o (m_ack_o),
    .m_err_o (m_err_o),
    .m_rty_o (m_rty_o),
    .s_adr_o (s_adr_o),
    .s_dat_o (s_dat_o),
    .s_sel_o (s_sel_o),
    .s_we_o  (s_we_o),
    .s_cyc_o (s_cyc_o),
    .s_stb_o (s_stb_o),
    .s_dat_i (s_dat_i),
    .s_ack_i (s_ack_i),
    .s_err_i (s_err_i),
    .s_rty_i (s_rty_i),
    .gnt_o   (gnt_o)
  );

  always #5 clk = ~clk;

  assign s_dat_i = {32'hD000_0022, 32'hD000_0011, 32'hD000_0000};
  assign s_ack_i = (ack_en | ack_force) & s_stb_o;

  function automatic logic [31:0] slave_dat(input int k);
    return 32'hD000_0000 + 32'h11 * k;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int m, input logic cyc, input logic we,
                       input logic [31:0] adr, input logic [31:0] dat);
    m_cyc[m]         = cyc;
    m_stb[m]         = cyc;
    m_we[m]          = we;
    m_adr[32*m +: 32] = adr;
    m_dat[32*m +: 32] = dat;
    m_sel[4*m +: 4]   = 4'hF;
  endtask

  task automatic push(input int m, input logic err, input logic chk, input logic [31:0] dat);
    exp_t e;
    e.m       = m;
    e.err     = err;
    e.chk_dat = chk;
    e.dat     = dat;
    sb.push_back(e);
  endtask

  // Every termination seen by a master is popped against the scoreboard.
  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (m_ack_o[m] || m_err_o[m]) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected m=%0d ack=%b err=%b required no termination", m, m_ack_o[m], m_err_o[m]);
        end else begin
          sb_e = sb.pop_front();
          if (sb_e.m != m || m_err_o[m] !== sb_e.err || m_ack_o[m] !== !sb_e.err ||
              (sb_e.chk_dat && m_dat_o !== sb_e.dat)) begin
            bad++;
            $display("FAIL sb_resp got m=%0d ack=%b err=%b dat=%h required m=%0d err=%b dat=%h",
                     m, m_ack_o[m], m_err_o[m], m_dat_o, sb_e.m, sb_e.err, sb_e.dat);
          end
        end
      end
    end
    if (m_rty_o !== 2'b00) begin
      total++;
      bad++;
      $display("FAIL rty got=%b required=00", m_rty_o);
    end
  end

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (gnt_o !== 2'b00 || s_cyc_o !== 3'b000 || s_stb_o !== 3'b000) begin
      bad++;
      $display("FAIL reset_state gnt=%b cyc=%b stb=%b required 00/000/000", gnt_o, s_cyc_o, s_stb_o);
    end
    total++;
    if ((m_ack_o | m_err_o) !== 2'b00) begin
      bad++;
      $display("FAIL reset_term ack=%b err=%b required 00", m_ack_o, m_err_o);
    end
    step;
    rst = 1'b0;
  endtask

  task automatic test_reset_priority;
    ack_en = 3'b001;
    step;
    set_m(0, 1'b1, 1'b0, 32'h0000_0010, '0);
    set_m(1, 1'b1, 1'b0, 32'h0000_0010, '0);
    push(0, 1'b0, 1'b1, slave_dat(0));
    @(negedge clk);
    total++;
    if (gnt_o !== 2'b00) begin bad++; $display("FAIL grant_latency gnt=%b required=00", gnt_o); end
    step;
    @(negedge clk);
    total++;
    if (gnt_o !== 2'b01) begin bad++; $display("FAIL first_grant gnt=%b required=01", gnt_o); end
    total++;
    if (s_stb_o !== 3'b001) begin bad++; $display("FAIL overlap_lowest stb=%b required=001", s_stb_o); end
    total++;
    if (m_ack_o !== 2'b01) begin bad++; $display("FAIL ack_comb ack=%b required=01", m_ack_o); end
    step;
    set_m(0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    total++;
    if (m_ack_o !== 2'b00) begin bad++; $display("FAIL ack_after_drop ack=%b required=00", m_ack_o); end
    step;
    push(1, 1'b0, 1'b1, slave_dat(0));
    @(negedge clk);
    total++;
    if (gnt_o !== 2'b00) begin bad++; $display("FAIL dead_cycle gnt=%b required=00", gnt_o); end
    step;
    @(negedge clk);
    total++;
    if (gnt_o !== 2'b10) begin bad++; $display("FAIL second_grant gnt=%b required=10", gnt_o); end
    step;
    set_m(1, 1'b0, 1'b0, '0, '0);
    step;
  endtask

  task automatic test_round_robin;
    int         acks [2];
    logic [1:0] just;
    logic [1:0] exp_g;
    acks[0] = 0;
    acks[1] = 0;
    just    = 2'b00;
    exp_g   = 2'b01;
    ack_en  = 3'b010;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) push(0, 1'b0, 1'b1, slave_dat(1));
      else            push(1, 1'b0, 1'b0, '0);
    end
    for (int n = 0; n < 80 && !(acks[0] == 3 && acks[1] == 3); n++) begin
      step;
      set_m(0, (acks[0] < 3) && !just[0], 1'b0, 32'h1000_0020, '0);
      set_m(1, (acks[1] < 3) && !just[1], 1'b1, 32'h1000_0040, 32'hCAFE_0001);
      @(negedge clk);
      just = m_ack_o;
      if (m_ack_o !== 2'b00) begin
        total++;
        if (gnt_o !== exp_g) begin bad++; $display("FAIL rr_order gnt=%b required=%b", gnt_o, exp_g); end
        if (m_ack_o[1]) begin
          total++;
          if (s_we_o !== 1'b1 || s_dat_o !== 32'hCAFE_0001 || s_adr_o !== 32'h1000_0040) begin
            bad++;
            $display("FAIL rr_write we=%b dat=%h adr=%h required 1/cafe0001/10000040", s_we_o, s_dat_o, s_adr_o);
          end
        end
        exp_g = ~exp_g;
      end
      for (int m = 0; m < 2; m++) if (m_ack_o[m]) acks[m]++;
    end
    total++;
    if (acks[0] != 3 || acks[1] != 3) begin
      bad++;
      $display("FAIL rr_budget acks0=%0d acks1=%0d required 3/3", acks[0], acks[1]);
    end
    step;
    set_m(0, 1'b0, 1'b0, '0, '0);
    set_m(1, 1'b0, 1'b0, '0, '0);
    step;
  endtask

  task automatic test_unmapped;
    ack_en = 3'b000;
    step;
    set_m(0, 1'b1, 1'b0, 32'h9000_0000, '0);
    push(0, 1'b1, 1'b0, '0);
    step;
    @(negedge clk);
    total++;
    if (s_stb_o !== 3'b000 || s_cyc_o !== 3'b000) begin
      bad++;
      $display("FAIL unmapped_nosel stb=%b cyc=%b required 000/000", s_stb_o, s_cyc_o);
    end
    total++;
    if (m_err_o !== 2'b00) begin bad++; $display("FAIL unmapped_early err=%b required=00", m_err_o); end
    step;
    @(negedge clk);
    total++;
    if (m_err_o !== 2'b01 || m_ack_o !== 2'b00) begin
      bad++;
      $display("FAIL unmapped_err err=%b ack=%b required 01/00", m_err_o, m_ack_o);
    end
    step;
    set_m(0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    total++;
    if (m_err_o !== 2'b00) begin bad++; $display("FAIL unmapped_width err=%b required=00", m_err_o); end
    step;
  endtask

  task automatic test_watchdog;
    ack_en    = 3'b000;
    ack_force = 3'b000;
    set_m(0, 1'b1, 1'b0, 32'h1000_0004, '0);
    push(0, 1'b1, 1'b0, '0);
    for (int c = 1; c <= 9; c++) begin
      step;
      @(negedge clk);
      total++;
      if (m_err_o !== ((c == 9) ? 2'b01 : 2'b00)) begin
        bad++;
        $display("FAIL wd_err cycle=%0d err=%b required=%b", c, m_err_o, (c == 9) ? 2'b01 : 2'b00);
      end
    end
    step;
    set_m(0, 1'b0, 1'b0, '0, '0);
    step;
    set_m(0, 1'b1, 1'b0, 32'h1000_0004, '0);
    push(0, 1'b0, 1'b1, slave_dat(1));
    for (int c = 1; c <= 9; c++) begin
      step;
      ack_force = (c == 8) ? 3'b010 : 3'b000;
      if (c == 9) set_m(0, 1'b0, 1'b0, '0, '0);
      @(negedge clk);
      if (c == 8) begin
        total++;
        if (m_ack_o !== 2'b01 || m_err_o !== 2'b00) begin
          bad++;
          $display("FAIL wd_ack_wins ack=%b err=%b required 01/00", m_ack_o, m_err_o);
        end
      end
      if (c == 9) begin
        total++;
        if (m_err_o !== 2'b00) begin bad++; $display("FAIL wd_no_err err=%b required=00", m_err_o); end
      end
    end
    ack_force = 3'b000;
    step;
  endtask

  task automatic test_reset_mid;
    ack_en = 3'b000;
    set_m(0, 1'b1, 1'b0, 32'h1000_0008, '0);
    step;
    @(negedge clk);
    total++;
    if (gnt_o !== 2'b01 || s_stb_o !== 3'b010) begin
      bad++;
      $display("FAIL mid_busy gnt=%b stb=%b required 01/010", gnt_o, s_stb_o);
    end
    step;
    set_m(1, 1'b1, 1'b0, 32'h1000_000C, '0);
    rst = 1'b1;
    step;
    @(negedge clk);
    total++;
    if (gnt_o !== 2'b00 || s_cyc_o !== 3'b000 || s_stb_o !== 3'b000 ||
        m_ack_o !== 2'b00 || m_err_o !== 2'b00) begin
      bad++;
      $display("FAIL mid_reset gnt=%b cyc=%b stb=%b ack=%b err=%b required all zero",
               gnt_o, s_cyc_o, s_stb_o, m_ack_o, m_err_o);
    end
    step;
    rst = 1'b0;
    step;
    @(negedge clk);
    total++;
    if (gnt_o !== 2'b01) begin bad++; $display("FAIL mid_regrant gnt=%b required=01", gnt_o); end
    step;
    set_m(0, 1'b0, 1'b0, '0, '0);
    set_m(1, 1'b0, 1'b0, '0, '0);
    step;
  endtask

  task automatic test_drain;
    repeat (2) step;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain pending=%0d required=0", sb.size());
    end
  endtask

  initial begin
    test_reset;
    test_reset_priority;
    test_round_robin;
    test_unmapped;
    test_watchdog;
    test_reset_mid;
    test_drain;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
